ram_arb2: RTL and testbench
===========================

RAM_ARB2 -- requirements
Module: ram_arb2

Interface
REQ-001 Parameter AW, default 13, RAM word-address width.
REQ-002 Parameter DW, default 32, data width; byte lanes = DW/8.
REQ-003 Parameter LOCK_MAX, default 16, max cycles a requester may hold a lock (1..255).
REQ-004 The block SHALL have one clock, CLK, and one reset, RST; RST is asynchronous and active-high.
REQ-005 CLK  in  1  clock; all state on rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 Rn_REQ  in  1  requester n (n=0,1) access request, held until granted.
REQ-008 Rn_LOCK  in  1  requester n asks to keep ownership after this access.
REQ-009 Rn_WE  in  DW/8  byte write enables; all-zero = read.
REQ-010 Rn_A  in  AW  word address.
REQ-011 Rn_Di  in  DW  write data.
REQ-012 Rn_GNT  out  1  access accepted this cycle (combinational).
REQ-013 Rn_RVALID  out  1  read data valid on Rn_Do this cycle.
REQ-014 Rn_Do  out  DW  read data; zero when Rn_RVALID=0.
REQ-015 RAM_EN  out  1; RAM_WE  out  DW/8; RAM_A  out  AW; RAM_Di  out  DW -- single-port RAM command.
REQ-016 RAM_Do  in  DW  RAM read data, valid the cycle after the RAM_EN cycle.

Function
REQ-017 At most one of R0_GNT/R1_GNT SHALL be high per cycle; RAM_EN = R0_GNT | R1_GNT.
REQ-018 RAM_WE/RAM_A/RAM_Di SHALL mirror the granted requester's inputs; all zero when no grant.
REQ-019 Grant is combinational from REQ and state; a granted access completes in that cycle (zero-wait).
REQ-020 State machine: IDLE, OWN0, OWN1.
REQ-021 IDLE, one requester: grant it. IDLE, both: grant the one not granted last (round-robin pointer LAST, updated on every grant).
REQ-022 IDLE -> OWNn when Rn_GNT=1 and Rn_LOCK=1; lock counter loads 1.
REQ-023 In OWNn only requester n SHALL be granted; the other's REQ is ignored (its GNT=0).
REQ-024 OWNn -> IDLE at the edge where Rn_LOCK=0, or where lock counter = LOCK_MAX (forced release); counter increments every OWNn cycle otherwise.
REQ-025 After forced release LAST = n, so the other requester wins the next contention.
REQ-026 Read (granted, WE=0): tag register captures n; next cycle Rn_RVALID=1 and Rn_Do=RAM_Do for exactly one cycle.
REQ-027 Write (WE!=0): no RVALID generated.
REQ-028 Back-to-back reads from alternating requesters SHALL each return data; throughput one access per cycle.
REQ-029 A requester dropping REQ without grant is legal; no state change.

Reset
REQ-030 On RST: state IDLE, LAST=1 (R0 wins first contention), lock counter 0, tag valid 0.
REQ-031 During and immediately after reset all GNT, RVALID, RAM_EN, RAM_WE SHALL be 0; Do outputs 0.
REQ-032 A read in flight at reset assertion SHALL produce no RVALID after reset.

Structure
REQ-033 State encoding enum and default LOCK_MAX belong in shared package ram_arb_pkg.
REQ-034 Round-robin pick SHALL be a sub-module rr_pick2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-035 Reset then R0,R1 REQ read A=0x0005 and A=0x1C00 same cycle -> R0_GNT cycle 1, R1_GNT cycle 2, each RVALID one cycle later with stored data.
REQ-036 R1 writes 0xDEADBEEF WE=0xF to 0x1FFF, then R0 reads 0x1FFF -> R0_Do=0xDEADBEEF, R1_RVALID stays 0.
REQ-037 R0 LOCK=1 for 3 accesses while R1 REQ high -> R1_GNT=0 until edge after R0_LOCK drops, then R1 granted.
REQ-038 LOCK_MAX=4, R0 holds LOCK and REQ indefinitely, R1 REQ -> forced release after 4 cycles, R1 granted next cycle.
REQ-039 Assert RST one cycle after a granted read -> no RVALID, all outputs 0, next contention granted to R0.
REQ-040 Byte write WE=0x2 data 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg -- shared types and defaults for the two-requester RAM arbiter.
//   arb_state_e  : ownership state of the arbiter (idle or locked to one requester)
//   LOCK_MAX_DEF : default maximum lock length in cycles
//   CNT_W        : lock counter width (covers LOCK_MAX up to 255)
package ram_arb_pkg;

  localparam int unsigned LOCK_MAX_DEF = 16;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2 -- two-way round-robin picker, purely combinational.
//   req  : request vector, bit n = requester n
//   last : index of the requester granted most recently
//   gnt  : one-hot grant (or zero when nobody requests)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arb2.sv
// ram_arb2 -- zero-wait arbiter sharing one single-port RAM between two requesters.
//   CLK, RST                 : clock, asynchronous active-high reset
//   Rn_REQ/LOCK/WE/A/Di      : requester n command (WE all-zero = read); LOCK keeps ownership
//   Rn_GNT                   : access accepted this cycle (combinational)
//   Rn_RVALID, Rn_Do         : read return, one cycle after the granted read
//   RAM_EN/WE/A/Di, RAM_Do   : single-port RAM command and its next-cycle read data
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic              R0_REQ,
  input  logic              R0_LOCK,
  input  logic [DW/8-1:0]   R0_WE,
  input  logic [AW-1:0]     R0_A,
  input  logic [DW-1:0]     R0_Di,
  output logic              R0_GNT,
  output logic              R0_RVALID,
  output logic [DW-1:0]     R0_Do,

  input  logic              R1_REQ,
  input  logic              R1_LOCK,
  input  logic [DW/8-1:0]   R1_WE,
  input  logic [AW-1:0]     R1_A,
  input  logic [DW-1:0]     R1_Di,
  output logic              R1_GNT,
  output logic              R1_RVALID,
  output logic [DW-1:0]     R1_Do,

  output logic              RAM_EN,
  output logic [DW/8-1:0]   RAM_WE,
  output logic [AW-1:0]     RAM_A,
  output logic [DW-1:0]     RAM_Di,
  input  logic [DW-1:0]     RAM_Do
);

  localparam int unsigned BW = DW / 8;

  arb_state_e       state_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tag_vld_q;
  logic             tag_id_q;

  logic [1:0]       pick;
  logic [1:0]       gnt;
  logic             rd_grant;
  logic             lock_hit;

  rr_pick2 u_pick (
    .req  ({R1_REQ, R0_REQ}),
    .last (last_q),
    .gnt  (pick)
  );

  // Grant: round-robin when idle, owner-only while locked, nothing during reset.
  always_comb begin
    gnt = 2'b00;
    case (state_q)
      ST_IDLE: gnt = pick;
      ST_OWN0: gnt = {1'b0, R0_REQ};
      ST_OWN1: gnt = {R1_REQ, 1'b0};
      default: gnt = 2'b00;
    endcase
    if (RST) begin
      gnt = 2'b00;
    end
  end

  assign R0_GNT = gnt[0];
  assign R1_GNT = gnt[1];
  assign RAM_EN = gnt[0] | gnt[1];

  // RAM command mirrors the granted requester, zero otherwise.
  always_comb begin
    RAM_WE = '0;
    RAM_A  = '0;
    RAM_Di = '0;
    if (gnt[0]) begin
      RAM_WE = R0_WE;
      RAM_A  = R0_A;
      RAM_Di = R0_Di;
    end else if (gnt[1]) begin
      RAM_WE = R1_WE;
      RAM_A  = R1_A;
      RAM_Di = R1_Di;
    end
  end

  assign rd_grant = RAM_EN && (RAM_WE == BW'(0));
  assign lock_hit = (cnt_q == CNT_W'(LOCK_MAX));

  // Ownership FSM, lock counter and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      if (gnt != 2'b00) begin
        last_q <= gnt[1];
      end
      case (state_q)
        ST_IDLE: begin
          if (gnt[0] && R0_LOCK) begin
            state_q <= ST_OWN0;
            cnt_q   <= CNT_W'(1);
          end else if (gnt[1] && R1_LOCK) begin
            state_q <= ST_OWN1;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_OWN0: begin
          if (!R0_LOCK || lock_hit) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            // Forced release hands the next contention to the other side.
            if (lock_hit) begin
              last_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_OWN1: begin
          if (!R1_LOCK || lock_hit) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            if (lock_hit) begin
              last_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Read tag: remembers who issued the read whose data returns next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
    end else begin
      tag_vld_q <= rd_grant;
      if (rd_grant) begin
        tag_id_q <= gnt[1];
      end
    end
  end

  assign R0_RVALID = tag_vld_q && !tag_id_q;
  assign R1_RVALID = tag_vld_q &&  tag_id_q;
  assign R0_Do     = R0_RVALID ? RAM_Do : '0;
  assign R1_Do     = R1_RVALID ? RAM_Do : '0;

endmodule

// File: tb/tb_ram_arb2.sv
// tb_ram_arb2 -- directed self-checking bench for ram_arb2 with a behavioural
// single-port RAM (read-first, byte enables, one-cycle read latency).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ram_arb2;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          CLK;
  logic          RST;
  logic          R0_REQ, R0_LOCK, R0_GNT, R0_RVALID;
  logic [BW-1:0] R0_WE;
  logic [AW-1:0] R0_A;
  logic [DW-1:0] R0_Di, R0_Do;
  logic          R1_REQ, R1_LOCK, R1_GNT, R1_RVALID;
  logic [BW-1:0] R1_WE;
  logic [AW-1:0] R1_A;
  logic [DW-1:0] R1_Di, R1_Do;
  logic          RAM_EN;
  logic [BW-1:0] RAM_WE;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_Di, RAM_Do;

  int checks;
  int errors;

  // Preload port into the RAM model, used only while the arbiter is quiet.
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_arb2 #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .R0_REQ(R0_REQ), .R0_LOCK(R0_LOCK), .R0_WE(R0_WE), .R0_A(R0_A), .R0_Di(R0_Di),
    .R0_GNT(R0_GNT), .R0_RVALID(R0_RVALID), .R0_Do(R0_Do),
    .R1_REQ(R1_REQ), .R1_LOCK(R1_LOCK), .R1_WE(R1_WE), .R1_A(R1_A), .R1_Di(R1_Di),
    .R1_GNT(R1_GNT), .R1_RVALID(R1_RVALID), .R1_Do(R1_Do),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_Di(RAM_Di), .RAM_Do(RAM_Do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (RAM_EN) begin
      RAM_Do <= mem[RAM_A];
      for (int b = 0; b < int'(BW); b++) begin
        if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
      end
    end
  end

  task automatic idle_inputs();
    R0_REQ = 1'b0; R0_LOCK = 1'b0; R0_WE = '0; R0_A = '0; R0_Di = '0;
    R1_REQ = 1'b0; R1_LOCK = 1'b0; R1_WE = '0; R1_A = '0; R1_Di = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    @(negedge CLK); #1;
    checks++; if (R0_GNT !== 1'b0 || R1_GNT !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b%b expected 00", R1_GNT, R0_GNT); end
    checks++; if (RAM_EN !== 1'b0 || RAM_WE !== 4'h0) begin errors++; $display("FAIL rst_ram: got en=%b we=%h expected 0/0", RAM_EN, RAM_WE); end
    checks++; if (R0_RVALID !== 1'b0 || R1_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b expected 00", R1_RVALID, R0_RVALID); end
    checks++; if (R0_Do !== 32'h0 || R1_Do !== 32'h0) begin errors++; $display("FAIL rst_do: got %h/%h expected 0/0", R0_Do, R1_Do); end
    idle_inputs();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK); #1;
    checks++; if (RAM_EN !== 1'b0 || R0_RVALID !== 1'b0 || R1_RVALID !== 1'b0 || R0_Do !== 32'h0) begin
      errors++; $display("FAIL post_rst_idle: got en=%b rv=%b%b do=%h expected all 0", RAM_EN, R1_RVALID, R0_RVALID, R0_Do);
    end
  endtask

  task automatic test_contention();
    @(negedge CLK);
    R0_REQ = 1'b1; R0_A = 13'h0005;
    R1_REQ = 1'b1; R1_A = 13'h1C00;
    #1;
    checks++; if (R0_GNT !== 1'b1 || R1_GNT !== 1'b0) begin errors++; $display("FAIL cont_c1_gnt: got %b%b expected 01", R1_GNT, R0_GNT); end
    checks++; if (RAM_EN !== 1'b1 || RAM_A !== 13'h0005) begin errors++; $display("FAIL cont_c1_ram: got en=%b a=%h expected 1/0005", RAM_EN, RAM_A); end
    @(negedge CLK);
    R0_REQ = 1'b0;
    #1;
    checks++; if (R1_GNT !== 1'b1 || RAM_A !== 13'h1C00) begin errors++; $display("FAIL cont_c2_gnt: got gnt1=%b a=%h expected 1/1c00", R1_GNT, RAM_A); end
    checks++; if (R0_RVALID !== 1'b1 || R0_Do !== 32'h1111_0005) begin errors++; $display("FAIL cont_r0_data: got %b/%h expected 1/11110005", R0_RVALID, R0_Do); end
    @(negedge CLK);
    R1_REQ = 1'b0;
    #1;
    checks++; if (R1_RVALID !== 1'b1 || R1_Do !== 32'h2222_1C00) begin errors++; $display("FAIL cont_r1_data: got %b/%h expected 1/22221c00", R1_RVALID, R1_Do); end
    checks++; if (R0_RVALID !== 1'b0 || R0_Do !== 32'h0) begin errors++; $display("FAIL cont_r0_quiet: got %b/%h expected 0/0", R0_RVALID, R0_Do); end
  endtask

  task automatic test_write_read();
    @(negedge CLK);
    idle_inputs();
    R1_REQ = 1'b1; R1_WE = 4'hF; R1_A = 13'h1FFF; R1_Di = 32'hDEAD_BEEF;
    #1;
    checks++; if (R1_GNT !== 1'b1 || RAM_WE !== 4'hF || RAM_Di !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_cmd: got gnt=%b we=%h di=%h expected 1/f/deadbeef", R1_GNT, RAM_WE, RAM_Di);
    end
    @(negedge CLK);
    idle_inputs();
    R0_REQ = 1'b1; R0_A = 13'h1FFF;
    #1;
    checks++; if (R0_GNT !== 1'b1 || R1_RVALID !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got gnt0=%b rv1=%b expected 1/0", R0_GNT, R1_RVALID); end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (R0_RVALID !== 1'b1 || R0_Do !== 32'hDEAD_BEEF || R1_RVALID !== 1'b0) begin
      errors++; $display("FAIL wr_readback: got rv0=%b do=%h rv1=%b expected 1/deadbeef/0", R0_RVALID, R0_Do, R1_RVALID);
    end
  endtask

  task automatic test_byte_write();
    @(negedge CLK);
    idle_inputs();
    R0_REQ = 1'b1; R0_WE = 4'h2; R0_A = 13'h0100; R0_Di = 32'h0000_AB00;
    #1;
    checks++; if (RAM_WE !== 4'h2 || RAM_A !== 13'h0100) begin errors++; $display("FAIL bw_cmd: got we=%h a=%h expected 2/0100", RAM_WE, RAM_A); end
    @(negedge CLK);
    R0_WE = 4'h0; R0_Di = '0;
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (R0_RVALID !== 1'b1 || R0_Do !== 32'h1122_AB44) begin errors++; $display("FAIL bw_merge: got %b/%h expected 1/1122ab44", R0_RVALID, R0_Do); end
  endtask

  task automatic test_lock();
    @(negedge CLK);
    idle_inputs();
    R0_REQ = 1'b1; R0_LOCK = 1'b1; R0_WE = 4'hF; R0_A = 13'h0010; R0_Di = 32'h1;
    #1;
    checks++; if (R0_GNT !== 1'b1) begin errors++; $display("FAIL lock_c1: got gnt0=%b expected 1", R0_GNT); end
    @(negedge CLK);
    R1_REQ = 1'b1; R1_A = 13'h0005;
    #1;
    checks++; if (R0_GNT !== 1'b1 || R1_GNT !== 1'b0) begin errors++; $display("FAIL lock_c2: got %b%b expected 01", R1_GNT, R0_GNT); end
    @(negedge CLK);
    R0_LOCK = 1'b0;
    #1;
    checks++; if (R0_GNT !== 1'b1 || R1_GNT !== 1'b0) begin errors++; $display("FAIL lock_c3: got %b%b expected 01", R1_GNT, R0_GNT); end
    @(negedge CLK);
    R0_REQ = 1'b0; R0_WE = '0;
    #1;
    checks++; if (R1_GNT !== 1'b1 || R0_GNT !== 1'b0) begin errors++; $display("FAIL lock_release: got %b%b expected 10", R1_GNT, R0_GNT); end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (R1_RVALID !== 1'b1 || R1_Do !== 32'h1111_0005) begin errors++; $display("FAIL lock_r1_data: got %b/%h expected 1/11110005", R1_RVALID, R1_Do); end
  endtask

  task automatic test_forced_release();
    @(negedge CLK);
    idle_inputs();
    R0_REQ = 1'b1; R0_LOCK = 1'b1; R0_WE = 4'hF; R0_A = 13'h0020; R0_Di = 32'h2;
    R1_REQ = 1'b1; R1_A = 13'h0005;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      checks++; if (R0_GNT !== 1'b1 || R1_GNT !== 1'b0) begin errors++; $display("FAIL force_hold[%0d]: got %b%b expected 01", i, R1_GNT, R0_GNT); end
    end
    @(negedge CLK); #1;
    checks++; if (R1_GNT !== 1'b1 || R0_GNT !== 1'b0) begin errors++; $display("FAIL force_release: got %b%b expected 10", R1_GNT, R0_GNT); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    @(negedge CLK);
    idle_inputs();
    R0_REQ = 1'b1; R0_A = 13'h0005;
    #1;
    checks++; if (R0_GNT !== 1'b1) begin errors++; $display("FAIL rif_gnt: got %b expected 1", R0_GNT); end
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    #1;
    checks++; if (R0_RVALID !== 1'b0 || R0_Do !== 32'h0 || RAM_EN !== 1'b0) begin
      errors++; $display("FAIL rif_during: got rv=%b do=%h en=%b expected 0/0/0", R0_RVALID, R0_Do, RAM_EN);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (R0_RVALID !== 1'b0 || R1_RVALID !== 1'b0) begin errors++; $display("FAIL rif_after: got %b%b expected 00", R1_RVALID, R0_RVALID); end
    @(negedge CLK);
    R0_REQ = 1'b1; R0_A = 13'h0005;
    R1_REQ = 1'b1; R1_A = 13'h1C00;
    #1;
    checks++; if (R0_GNT !== 1'b1 || R1_GNT !== 1'b0) begin errors++; $display("FAIL rif_first_cont: got %b%b expected 01", R1_GNT, R0_GNT); end
    @(negedge CLK);
    R0_REQ = 1'b0;
    #1;
    checks++; if (R0_RVALID !== 1'b1 || R0_Do !== 32'h1111_0005) begin errors++; $display("FAIL rif_r0_data: got %b/%h expected 1/11110005", R0_RVALID, R0_Do); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [0:3];
    exp_d[0] = 32'h1111_0005;
    exp_d[1] = 32'h2222_1C00;
    exp_d[2] = 32'h1111_0005;
    exp_d[3] = 32'h2222_1C00;
    @(negedge CLK);
    idle_inputs();
    R0_REQ = 1'b1; R0_A = 13'h0005;
    R1_REQ = 1'b1; R1_A = 13'h1C00;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == 4) idle_inputs();
      #1;
      if (i < 4) begin
        checks++;
        if (R0_GNT !== ((i % 2) == 0) || R1_GNT !== ((i % 2) == 1)) begin
          errors++; $display("FAIL b2b_gnt[%0d]: got %b%b expected %b%b", i, R1_GNT, R0_GNT, ((i % 2) == 1), ((i % 2) == 0));
        end
      end
      if (i > 0) begin
        checks++;
        if ((i % 2) == 1) begin
          if (R0_RVALID !== 1'b1 || R0_Do !== exp_d[i-1] || R1_RVALID !== 1'b0) begin
            errors++; $display("FAIL b2b_data[%0d]: got rv0=%b do0=%h rv1=%b expected 1/%h/0", i, R0_RVALID, R0_Do, R1_RVALID, exp_d[i-1]);
          end
        end else begin
          if (R1_RVALID !== 1'b1 || R1_Do !== exp_d[i-1] || R0_RVALID !== 1'b0) begin
            errors++; $display("FAIL b2b_data[%0d]: got rv1=%b do1=%h rv0=%b expected 1/%h/0", i, R1_RVALID, R1_Do, R0_RVALID, exp_d[i-1]);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pl_en  = 1'b0;
    pl_a   = '0;
    pl_d   = '0;
    RST    = 1'b1;
    idle_inputs();
    test_reset();
    preload(13'h0005, 32'h1111_0005);
    preload(13'h1C00, 32'h2222_1C00);
    preload(13'h0100, 32'h1122_3344);
    test_contention();
    test_write_read();
    test_byte_write();
    test_lock();
    test_forced_release();
    test_reset_inflight();
    test_back_to_back();
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
